// File: rtl/cpu_isa_pkg.sv
// Instruction field layout shared by the program-load encoder and the core decoder.
// Holds the bit positions, the decoded-field struct, the encoder FSM states and pack helpers.
package cpu_isa_pkg;

    localparam int INSTR_W = 32;
    localparam int REG_W   = 6;
    localparam int FX_W    = 4;
    localparam int IMM_W   = 15;
    localparam int IMM_R_W = 9;

    localparam int RI_BIT    = 31;
    localparam int RS_MSB    = 30;
    localparam int RS_LSB    = 25;
    localparam int RD_MSB    = 24;
    localparam int RD_LSB    = 19;
    localparam int FX_MSB    = 18;
    localparam int FX_LSB    = 15;
    localparam int RT_MSB    = 14;
    localparam int RT_LSB    = 9;
    localparam int IMM_MSB   = 14;
    localparam int IMM_R_MSB = 8;
    localparam int IMM_LSB   = 0;

    typedef struct packed {
        logic             ri;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rd;
        logic [FX_W-1:0]  fx;
        logic [REG_W-1:0] rt;
        logic [IMM_W-1:0] imm;
    } instr_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } enc_state_e;

    function automatic logic [INSTR_W-1:0] pack_instr(input instr_fields_t f);
        logic [INSTR_W-1:0] w;
        w                 = '0;
        w[RI_BIT]         = f.ri;
        w[RS_MSB:RS_LSB]  = f.rs;
        w[RD_MSB:RD_LSB]  = f.rd;
        w[FX_MSB:FX_LSB]  = f.fx;
        if (f.ri) begin
            w[IMM_MSB:IMM_LSB] = f.imm;
        end else begin
            w[RT_MSB:RT_LSB]     = f.rt;
            w[IMM_R_MSB:IMM_LSB] = f.imm[IMM_R_W-1:0];
        end
        return w;
    endfunction

    // An R-type word only has room for a 9-bit immediate; anything wider cannot be encoded.
    function automatic logic is_rejected(input instr_fields_t f);
        return !f.ri && (f.imm[IMM_W-1:IMM_R_W] != '0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: rdata is the head entry whenever empty is low.
// Pointers carry one extra bit so full and empty are told apart without a separate flag.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program-load path: packs field tuples into instruction words, buffers them in a FIFO
// and streams them to instruction memory from a programmable base address.
module instr_encoder
    import cpu_isa_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic               in_ri,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [FX_W-1:0]    in_fx,
    input  logic [REG_W-1:0]   in_rt,
    input  logic [IMM_W-1:0]   in_imm,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic [7:0]         err_cnt,
    output logic               wrapped
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    enc_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wrapped_q, wrapped_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    instr_fields_t       fields;
    logic [INSTR_W-1:0]  word;
    logic                reject, accept, push, pop;
    logic [INSTR_W-1:0]  fifo_rdata;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    always_comb begin
        fields = '{ri: in_ri, rs: in_rs, rd: in_rd, fx: in_fx, rt: in_rt, imm: in_imm};
    end

    assign word     = pack_instr(fields);
    assign reject   = is_rejected(fields);
    assign in_ready = (state_q == ST_LOAD) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && !reject;
    assign pop      = mem_we && mem_ready;

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    addr_d    = base_addr;
                    wrapped_d = 1'b0;
                    err_cnt_d = '0;
                end
            end
            ST_LOAD:  if (accept && in_last) state_d = ST_DRAIN;
            // Leave as the last word retires so done lands in the very next cycle.
            ST_DRAIN: if (fifo_empty || (pop && fifo_count == CNT_W'(1))) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == '1) wrapped_d = 1'b1;
        end

        if (accept && reject && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wrapped_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign mem_we    = !fifo_empty;
    assign mem_wdata = fifo_empty ? '0 : fifo_rdata;
    assign mem_addr  = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err_cnt   = err_cnt_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: an independent word model feeds a scoreboard queue
// that a negedge monitor drains as memory writes complete.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic        in_ri;
    logic [5:0]  in_rs, in_rd, in_rt;
    logic [3:0]  in_fx;
    logic [14:0] in_imm;
    logic        mem_we;
    logic        mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;
    logic        wrapped;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [9:0]  exp_addr;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          n_done   = 0;

    always #5 clk = ~clk;

    instr_encoder #(
        .DEPTH  (4),
        .ADDR_W (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_ri     (in_ri),
        .in_rs     (in_rs),
        .in_rd     (in_rd),
        .in_fx     (in_fx),
        .in_rt     (in_rt),
        .in_imm    (in_imm),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .wrapped   (wrapped)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] model_word(input logic ri, input logic [5:0] rs, input logic [5:0] rd,
                                               input logic [3:0] fx, input logic [5:0] rt, input logic [14:0] imm);
        if (ri) return {1'b1, rs, rd, fx, imm};
        return {1'b0, rs, rd, fx, rt, imm[8:0]};
    endfunction

    // Writes complete on the next rising edge; inputs are steady at the falling edge.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            exp_t e;
            n_writes++;
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e.addr);
                check("write_data", mem_wdata, e.data);
            end
        end
        if (!rst && done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [9:0] base);
        start     = 1'b1;
        base_addr = base;
        exp_addr  = base;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("addr_after_start", mem_addr, base);
    endtask

    task automatic send(input logic ri, input logic [5:0] rs, input logic [5:0] rd, input logic [3:0] fx,
                        input logic [5:0] rt, input logic [14:0] imm, input logic last);
        int waited = 0;
        exp_t e;
        in_valid = 1'b1;
        in_ri = ri; in_rs = rs; in_rd = rd; in_fx = fx; in_rt = rt; in_imm = imm; in_last = last;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        check("send_accept", in_ready, 1);
        if (in_ready && !(!ri && imm[14:9] != 6'd0)) begin
            e.addr = exp_addr;
            e.data = model_word(ri, rs, rd, fx, rt, imm);
            exp_q.push_back(e);
            exp_addr = exp_addr + 10'd1;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_load();
        int waited = 0;
        while (!done && waited < 100) begin
            tick();
            waited++;
        end
        check("done_seen", done, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_wrapped"}, wrapped, 0);
    endtask

    initial begin
        int w0, d0;
        logic [31:0] head_word;

        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_ri = 1'b0; in_rs = '0; in_rd = '0; in_rt = '0; in_fx = '0; in_imm = '0; mem_ready = 1'b1;
        tick();
        tick();
        check_reset_values("por");
        rst = 1'b0;
        tick();

        // R-type encode, then done one cycle after the write.
        start_load(10'h010);
        send(1'b0, 6'd3, 6'd5, 4'd2, 6'd7, 15'h001F, 1'b1);
        check("rtype_we", mem_we, 1);
        check("rtype_wdata", mem_wdata, 32'h06290E1F);
        check("rtype_addr", mem_addr, 10'h010);
        tick();
        check("rtype_done_next", done, 1);
        finish_load();

        // I-type encode: rt must not appear in the word.
        start_load(10'h020);
        w0 = n_writes;
        send(1'b1, 6'd1, 6'd2, 4'hF, 6'h3F, 15'h7FFF, 1'b1);
        check("itype_wdata", mem_wdata, 32'h8217FFFF);
        finish_load();
        check("itype_writes", n_writes - w0, 1);

        // Rejected R-type followed by a good tuple.
        start_load(10'h040);
        w0 = n_writes;
        send(1'b0, 6'd4, 6'd4, 4'd1, 6'd9, 15'h0200, 1'b0);
        check("reject_err_cnt_1", err_cnt, 1);
        send(1'b0, 6'd8, 6'd9, 4'd3, 6'd10, 15'h01AB, 1'b1);
        finish_load();
        check("reject_err_cnt", err_cnt, 1);
        check("reject_writes", n_writes - w0, 1);

        // A rejected tuple carrying last still ends the load, with no write.
        start_load(10'h050);
        check("err_cnt_cleared", err_cnt, 0);
        w0 = n_writes;
        send(1'b0, 6'd1, 6'd1, 4'd1, 6'd1, 15'h7E00, 1'b1);
        finish_load();
        check("reject_last_err", err_cnt, 1);
        check("reject_last_writes", n_writes - w0, 0);

        // Backpressure: fill the FIFO with memory stalled.
        mem_ready = 1'b0;
        start_load(10'h100);
        w0 = n_writes;
        send(1'b0, 6'd1, 6'd2, 4'd3, 6'd4, 15'h0005, 1'b0);
        send(1'b1, 6'd6, 6'd7, 4'd8, 6'd9, 15'h4321, 1'b0);
        send(1'b0, 6'd11, 6'd12, 4'd13, 6'd14, 15'h01FF, 1'b0);
        send(1'b1, 6'd16, 6'd17, 4'd2, 6'd19, 15'h1234, 1'b0);
        check("bp_in_ready_full", in_ready, 0);
        check("bp_mem_we", mem_we, 1);
        head_word = exp_q[0].data;
        check("bp_head_word", mem_wdata, head_word);
        in_valid  = 1'b1;
        start     = 1'b1;
        base_addr = 10'h155;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("bp_in_ready_held", in_ready, 0);
        check("bp_wdata_stable", mem_wdata, head_word);
        check("bp_addr_stable", mem_addr, 10'h100);
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        send(1'b0, 6'd21, 6'd22, 4'd5, 6'd23, 15'h0077, 1'b0);
        send(1'b1, 6'd24, 6'd25, 4'd6, 6'd26, 15'h6000, 1'b1);
        finish_load();
        check("bp_writes", n_writes - w0, 6);

        // Address wrap at the top of the 10-bit space.
        start_load(10'h3FE);
        check("wrap_clear_at_start", wrapped, 0);
        w0 = n_writes;
        send(1'b1, 6'd1, 6'd1, 4'd1, 6'd0, 15'h0001, 1'b0);
        send(1'b1, 6'd2, 6'd2, 4'd2, 6'd0, 15'h0002, 1'b0);
        send(1'b0, 6'd3, 6'd3, 4'd3, 6'd3, 15'h0003, 1'b1);
        finish_load();
        check("wrap_sticky", wrapped, 1);
        check("wrap_writes", n_writes - w0, 3);
        check("wrap_final_addr", mem_addr, 10'h001);

        // Reset while two entries are queued.
        mem_ready = 1'b0;
        start_load(10'h200);
        check("new_load_wrapped_clear", wrapped, 0);
        send(1'b1, 6'd5, 6'd5, 4'd5, 6'd5, 15'h0055, 1'b0);
        send(1'b1, 6'd6, 6'd6, 4'd6, 6'd6, 15'h0066, 1'b0);
        check("mid_load_we", mem_we, 1);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        exp_q.delete();
        rst       = 1'b0;
        mem_ready = 1'b1;
        w0 = n_writes;
        d0 = n_done;
        repeat (10) tick();
        check("midrst_no_writes", n_writes - w0, 0);
        check("midrst_no_done", n_done - d0, 0);
        check("midrst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs decoded instruction fields (RI, rs, rd, fx, rt, imm) into 32-bit instruction words and streams them into instruction memory through a write port with backpressure. The block is the program-load path of the processor: the test host or boot sequencer feeds it field tuples, and the core's instruction decoder later splits the words it writes. A small FIFO decouples field input from memory writes. An address counter sequences writes from a programmable base address.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `ADDR_W`, default 10: instruction-memory word-address width.
- `clk` input 1: clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a load; honoured only in IDLE.
- `base_addr` input ADDR_W: first write address; sampled when `start` is honoured.
- `in_valid` input 1: field tuple valid.
- `in_ready` output 1: block can accept a tuple.
- `in_last` input 1: marks the final tuple of a load.
- `in_ri` input 1: 1 = I-type, 0 = R-type.
- `in_rs`, `in_rd`, `in_rt` input 6 each: register fields.
- `in_fx` input 4: function field.
- `in_imm` input 15: immediate.
- `mem_we` output 1: write request valid.
- `mem_ready` input 1: memory accepts the write this cycle.
- `mem_addr` output ADDR_W: write word address.
- `mem_wdata` output 32: encoded word.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse when a load completes.
- `err_cnt` output 8: count of rejected tuples; saturates at 255.
- `wrapped` output 1: sticky; address counter wrapped during this load.

## Operation
- Word format:
  - [31] RI; [30:25] rs; [24:19] rd; [18:15] fx.
  - R-type: [14:9] rt, [8:0] imm[8:0].
  - I-type: [14:0] imm; `in_rt` is ignored.
- Reject rule: an R-type tuple with imm[14:9] ≠ 0 is dropped, never enqueued, and increments `err_cnt`.
- FSM: IDLE → LOAD → DRAIN → DONE → IDLE.
  - IDLE: `start` → LOAD. On that edge, `mem_addr` ← `base_addr`, `wrapped` ← 0, `err_cnt` ← 0.
  - LOAD: `in_ready` = !full. A tuple is accepted when `in_valid && in_ready`. Accepting a tuple with `in_last` moves to DRAIN, including when that tuple is rejected.
  - DRAIN: `in_ready` = 0. When the FIFO is empty and no write is pending, move to DONE.
  - DONE: `done` = 1 for exactly one cycle, then IDLE.
- Memory write:
  - `mem_we` = FIFO not empty; `mem_wdata` = FIFO head (show-ahead).
  - The write completes in a cycle where `mem_we && mem_ready`. On that edge the FIFO pops and `mem_addr` increments.
  - `mem_addr` wraps at 2^ADDR_W−1 → 0 and sets `wrapped`.
- `start` outside IDLE is ignored.
- Full FIFO: no push that cycle, even if a pop happens in the same cycle; `in_ready` depends on full only.
- Reset mid-load: FIFO contents are discarded, the FSM returns to IDLE, and no partial `done` is produced.

## Timing
- Reset values: `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `err_cnt` 0, `wrapped` 0.
- Accept at edge N → `mem_we`/`mem_wdata` visible in cycle N+1 when the FIFO was empty.
- With `mem_ready` held high, sustained throughput is one word per cycle.
- `done` asserts in the cycle after the final write completes.
- `in_ready` is combinational from state and the full flag; it never depends on `in_valid`.
- `mem_wdata` and `mem_addr` stay stable while `mem_we && !mem_ready`.

## Structure
- Shared package `cpu_isa_pkg` holds:
  - field bit-position and width localparams (RI_BIT, RS_MSB/LSB, …);
  - struct `instr_fields_t`;
  - enum `enc_state_e`.
  - The core decoder uses the same constants.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): show-ahead, with full/empty flags and synchronous reset.
- The encoder body (pack, reject check, FSM, address counter) stays in `instr_encoder`.

## Test plan
- R-type encode: start with base 0x010; send ri=0, rs=3, rd=5, fx=2, rt=7, imm=0x01F with last. Expect one write of 0x06290E1F at 0x010, then `done` one cycle later.
- I-type encode: ri=1, rs=1, rd=2, fx=0xF, rt=0x3F, imm=0x7FFF. Expect `mem_wdata` = 0x8217FFFF (rt ignored).
- Reject: R-type with imm=0x200, then a valid tuple with last. Expect `err_cnt`=1 and exactly one write, at the base address.
- Backpressure: hold `mem_ready`=0 and send 6 tuples with DEPTH=4. Expect `in_ready` low after 4 accepts and `mem_wdata`/`mem_addr` stable. Release `mem_ready`; expect 6 writes at consecutive addresses, in order.
- Wrap: base 0x3FE (ADDR_W=10), 3 tuples. Expect writes at 0x3FE, 0x3FF, 0x000 and `wrapped`=1.
- Reset mid-load: assert `rst` while 2 entries are queued. Expect all outputs at reset values the next cycle, no further writes, and no `done`.
